// File: rtl/pipeline_hazard_sequencer_if.sv
// Signal bundle between the ID-stage decoder/datapath and the hazard sequencer.
// The master side supplies decoded ID controls and the EX zero flag; the slave side returns pipeline controls.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              regWrite_ID;
    logic              memToReg_ID;
    logic              memWrite_ID;
    logic              branch_ID;
    logic [2:0]        aluControl_ID;
    logic              aluSrc_ID;
    logic              regDst_ID;
    logic [REG_AW-1:0] rs_ID;
    logic [REG_AW-1:0] rt_ID;
    logic [REG_AW-1:0] rd_ID;
    logic              zero_E;

    logic              regWrite_E;
    logic              memToReg_E;
    logic              memWrite_E;
    logic              branch_E;
    logic              aluSrc_E;
    logic [2:0]        aluControl_E;
    logic [REG_AW-1:0] writeReg_E;
    logic              regWrite_M;
    logic              memToReg_M;
    logic              memWrite_M;
    logic [REG_AW-1:0] writeReg_M;
    logic              regWrite_W;
    logic              memToReg_W;
    logic [REG_AW-1:0] writeReg_W;
    logic              pcSrc_E;
    logic              stall_F;
    logic              stall_D;
    logic              flush_D;
    logic              flush_E;
    logic [1:0]        forwardA_E;
    logic [1:0]        forwardB_E;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output regWrite_ID, memToReg_ID, memWrite_ID, branch_ID, aluControl_ID,
               aluSrc_ID, regDst_ID, rs_ID, rt_ID, rd_ID, zero_E,
        input  regWrite_E, memToReg_E, memWrite_E, branch_E, aluSrc_E, aluControl_E,
               writeReg_E, regWrite_M, memToReg_M, memWrite_M, writeReg_M,
               regWrite_W, memToReg_W, writeReg_W, pcSrc_E, stall_F, stall_D,
               flush_D, flush_E, forwardA_E, forwardB_E, stall_count, flush_count
    );

    modport slave (
        input  regWrite_ID, memToReg_ID, memWrite_ID, branch_ID, aluControl_ID,
               aluSrc_ID, regDst_ID, rs_ID, rt_ID, rd_ID, zero_E,
        output regWrite_E, memToReg_E, memWrite_E, branch_E, aluSrc_E, aluControl_E,
               writeReg_E, regWrite_M, memToReg_M, memWrite_M, writeReg_M,
               regWrite_W, memToReg_W, writeReg_W, pcSrc_E, stall_F, stall_D,
               flush_D, flush_E, forwardA_E, forwardB_E, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Carries ID control words through E/M/W, resolves load-use and bne-taken hazards,
// selects EX operand forwarding and keeps saturating stall/flush event counters.
module pipeline_hazard_sequencer #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              r_regWrite_E;
    logic              r_memToReg_E;
    logic              r_memWrite_E;
    logic              r_branch_E;
    logic [2:0]        r_aluControl_E;
    logic              r_aluSrc_E;
    logic              r_regDst_E;
    logic [REG_AW-1:0] r_rs_E;
    logic [REG_AW-1:0] r_rt_E;
    logic [REG_AW-1:0] r_rd_E;
    logic              r_regWrite_M;
    logic              r_memToReg_M;
    logic              r_memWrite_M;
    logic [REG_AW-1:0] r_writeReg_M;
    logic              r_regWrite_W;
    logic              r_memToReg_W;
    logic [REG_AW-1:0] r_writeReg_W;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic              w_lwstall;
    logic              w_pcSrc;
    logic              w_stall;
    logic              w_flush_E;
    logic [REG_AW-1:0] w_writeReg_E;
    logic [REG_AW-1:0] w_src [2];
    logic [1:0]        w_fwd [2];

    assign w_writeReg_E = r_regDst_E ? r_rd_E : r_rt_E;

    assign w_lwstall = r_memToReg_E & r_regWrite_E & (r_rt_E != '0) &
                       ((r_rt_E == bus.rs_ID) | (r_rt_E == bus.rt_ID));
    assign w_pcSrc   = r_branch_E & ~bus.zero_E;
    // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
    assign w_stall   = w_lwstall & ~w_pcSrc;
    assign w_flush_E = w_pcSrc | w_lwstall;

    assign w_src[0] = r_rs_E;
    assign w_src[1] = r_rt_E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] =
                (r_regWrite_M && (r_writeReg_M != '0) && (r_writeReg_M == w_src[gi])) ? 2'b10 :
                (r_regWrite_W && (r_writeReg_W != '0) && (r_writeReg_W == w_src[gi])) ? 2'b01 :
                                                                                         2'b00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regWrite_E   <= 1'b0;
            r_memToReg_E   <= 1'b0;
            r_memWrite_E   <= 1'b0;
            r_branch_E     <= 1'b0;
            r_aluControl_E <= '0;
            r_aluSrc_E     <= 1'b0;
            r_regDst_E     <= 1'b0;
            r_rs_E         <= '0;
            r_rt_E         <= '0;
            r_rd_E         <= '0;
            r_regWrite_M   <= 1'b0;
            r_memToReg_M   <= 1'b0;
            r_memWrite_M   <= 1'b0;
            r_writeReg_M   <= '0;
            r_regWrite_W   <= 1'b0;
            r_memToReg_W   <= 1'b0;
            r_writeReg_W   <= '0;
            r_stall_count  <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_flush_E) begin
                r_regWrite_E   <= 1'b0;
                r_memToReg_E   <= 1'b0;
                r_memWrite_E   <= 1'b0;
                r_branch_E     <= 1'b0;
                r_aluControl_E <= '0;
                r_aluSrc_E     <= 1'b0;
                r_regDst_E     <= 1'b0;
                r_rs_E         <= '0;
                r_rt_E         <= '0;
                r_rd_E         <= '0;
            end else begin
                r_regWrite_E   <= bus.regWrite_ID;
                r_memToReg_E   <= bus.memToReg_ID;
                r_memWrite_E   <= bus.memWrite_ID;
                r_branch_E     <= bus.branch_ID;
                r_aluControl_E <= bus.aluControl_ID;
                r_aluSrc_E     <= bus.aluSrc_ID;
                r_regDst_E     <= bus.regDst_ID;
                r_rs_E         <= bus.rs_ID;
                r_rt_E         <= bus.rt_ID;
                r_rd_E         <= bus.rd_ID;
            end

            r_regWrite_M <= r_regWrite_E;
            r_memToReg_M <= r_memToReg_E;
            r_memWrite_M <= r_memWrite_E;
            r_writeReg_M <= w_writeReg_E;
            r_regWrite_W <= r_regWrite_M;
            r_memToReg_W <= r_memToReg_M;
            r_writeReg_W <= r_writeReg_M;

            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
            if (w_pcSrc && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign bus.regWrite_E   = r_regWrite_E;
    assign bus.memToReg_E   = r_memToReg_E;
    assign bus.memWrite_E   = r_memWrite_E;
    assign bus.branch_E     = r_branch_E;
    assign bus.aluSrc_E     = r_aluSrc_E;
    assign bus.aluControl_E = r_aluControl_E;
    assign bus.writeReg_E   = w_writeReg_E;
    assign bus.regWrite_M   = r_regWrite_M;
    assign bus.memToReg_M   = r_memToReg_M;
    assign bus.memWrite_M   = r_memWrite_M;
    assign bus.writeReg_M   = r_writeReg_M;
    assign bus.regWrite_W   = r_regWrite_W;
    assign bus.memToReg_W   = r_memToReg_W;
    assign bus.writeReg_W   = r_writeReg_W;
    assign bus.pcSrc_E      = w_pcSrc;
    assign bus.stall_F      = w_stall;
    assign bus.stall_D      = w_stall;
    assign bus.flush_D      = w_pcSrc;
    assign bus.flush_E      = w_flush_E;
    assign bus.forwardA_E   = w_fwd[0];
    assign bus.forwardB_E   = w_fwd[1];
    assign bus.stall_count  = r_stall_count;
    assign bus.flush_count  = r_flush_count;
endmodule
